instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter LAST_ADDR, default 300, meaning the highest legal fetch byte address.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, meaning reset: synchronous, active-low.
REQ-005 SHALL have port instruction, input, 32, meaning the combinational read data from the instruction memory for the word at address.
REQ-006 SHALL have port address, output, 32, meaning the current PC, driven to the instruction memory.
REQ-007 SHALL have port stall, input, 1, meaning hold the PC and the IF/ID register.
REQ-008 SHALL have port branch_taken, input, 1, meaning redirect from downstream.
REQ-009 SHALL have port branch_target, input, 32, meaning the redirect byte address.
REQ-010 SHALL have port if_id_valid, output, 1, meaning the IF/ID register holds a live instruction.
REQ-011 SHALL have port if_id_instruction, output, 32, meaning the latched instruction.
REQ-012 SHALL have port if_id_pc_plus4, output, 32, meaning the latched PC+4 of that instruction.
REQ-013 SHALL have port halted, output, 1, meaning the unit is in HALT.
REQ-014 SHALL have port fetch_count, output, 32, meaning the count of valid IF/ID loads, saturating at 32'hFFFF_FFFF.

Function
REQ-015 SHALL implement FSM states RUN and HALT, entering RUN on reset.
REQ-016 SHALL, in RUN with stall=0 and branch_taken=0 and a legal PC, each cycle set IF/ID to {instruction, address+4, valid=1}, set PC to address+4, and increment fetch_count.
REQ-017 SHALL define a legal PC as address[1:0]==0 and address<=LAST_ADDR; PC arithmetic is modulo 2^32.
REQ-018 SHALL, when branch_taken=1 in RUN, load PC from branch_target, clear if_id_valid (flush), and leave fetch_count unchanged; branch_taken overrides stall.
REQ-019 SHALL, when stall=1 and branch_taken=0, hold PC, IF/ID and fetch_count unchanged.
REQ-020 SHALL, when RUN has an illegal PC and branch_taken=0, transition to HALT, clear if_id_valid, and hold PC.
REQ-021 SHALL, in HALT, ignore stall and branch_taken, keep halted=1 and if_id_valid=0, and leave HALT only on reset.
REQ-022 SHALL load an illegal branch_target into PC, with HALT entered on the following cycle.
REQ-023 SHALL drive address combinationally from the PC register, giving a fetch latency of 1 cycle from PC to IF/ID.

Reset
REQ-024 SHALL, on a clock edge with reset=0, set PC=RESET_PC, state=RUN, if_id_valid=0, if_id_instruction=0, if_id_pc_plus4=0, halted=0, fetch_count=0.
REQ-025 SHALL give reset priority over all inputs, including mid-stall and in HALT.

Configuration
REQ-026 SHALL, with FETCH_JUMP_EN defined, on a valid fetch whose instruction[31:26]==6'b000010, set next PC={address_plus4[31:28], instruction[25:0], 2'b00}, still load IF/ID valid (no bubble), with branch_taken taking priority.
REQ-027 SHALL, without FETCH_JUMP_EN, treat jump opcodes like any other opcode (PC+4).

Structure
REQ-028 SHALL place the FSM state enum, the OPC_J constant (6'b000010) and the word-size constant (4) in shared package fetch_pkg.
REQ-029 SHALL use one sub-module, pc_register (PC flop with sync active-low reset and load enable).

Verification
REQ-030 SHALL cover reset then run: after release, address=0, instruction=32'h02324020, next edge gives if_id_instruction=32'h02324020, if_id_pc_plus4=4, address=4, fetch_count=1.
REQ-031 SHALL cover stall: stall=1 for 3 cycles at address=8, then address, IF/ID and fetch_count are unchanged, and fetching resumes at 8 on release.
REQ-032 SHALL cover branch+stall: branch_taken=1, branch_target=32'h48, stall=1 at address=8, then next address=72 with if_id_valid=0.
REQ-033 SHALL cover illegal addresses: branch_target=32'h4A gives address=0x4A then HALT next cycle with halted=1; run past LAST_ADDR (address=304) gives HALT; asserting reset clears it.
REQ-034 SHALL cover FETCH_JUMP_EN: instruction=32'h08000012 at address=0x10 gives next address=0x48 with if_id_valid=1; without the macro, the next address is 0x14.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam logic [5:0]  OPC_J      = 6'b000010;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter flop with synchronous active-low reset and load enable.
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, IF/ID register and RUN/HALT control.
// Optional direct-jump decode at fetch is enabled by defining FETCH_JUMP_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] LAST_ADDR = 32'd300
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] address,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instruction,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic            halted,
    output logic [XLEN-1:0] fetch_count
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic            pc_load;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] seq_pc_c;
    logic            pc_legal_c;
    logic            valid_nxt;
    logic [XLEN-1:0] instr_nxt;
    logic [XLEN-1:0] pc_plus4_nxt;
    logic [XLEN-1:0] count_nxt;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock (clock),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_nxt),
        .q     (address)
    );

    assign pc_plus4   = address + XLEN'(WORD_BYTES);
    assign pc_legal_c = (address[1:0] == 2'b00) && (address <= LAST_ADDR);

`ifdef FETCH_JUMP_EN
    assign seq_pc_c = (instruction[31:26] == OPC_J)
                    ? {pc_plus4[31:28], instruction[25:0], 2'b00}
                    : pc_plus4;
`else
    assign seq_pc_c = pc_plus4;
`endif

    assign halted = (state == HALT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect beats everything; an illegal PC halts before a stall can hold it.
    always_comb begin
        state_nxt    = state;
        pc_load      = 1'b0;
        pc_nxt       = address;
        valid_nxt    = if_id_valid;
        instr_nxt    = if_id_instruction;
        pc_plus4_nxt = if_id_pc_plus4;
        count_nxt    = fetch_count;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    pc_load   = 1'b1;
                    pc_nxt    = branch_target;
                    valid_nxt = 1'b0;
                end else if (!pc_legal_c) begin
                    state_nxt = HALT;
                    valid_nxt = 1'b0;
                end else if (!stall) begin
                    pc_load      = 1'b1;
                    pc_nxt       = seq_pc_c;
                    valid_nxt    = 1'b1;
                    instr_nxt    = instruction;
                    pc_plus4_nxt = pc_plus4;
                    if (fetch_count != '1) begin
                        count_nxt = fetch_count + XLEN'(1);
                    end
                end
            end
            HALT: begin
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = HALT;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= '0;
            if_id_pc_plus4    <= '0;
            fetch_count       <= '0;
        end else begin
            if_id_valid       <= valid_nxt;
            if_id_instruction <= instr_nxt;
            if_id_pc_plus4    <= pc_plus4_nxt;
            fetch_count       <= count_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a small combinational instruction memory.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] address;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] imem [128];
    int          checks;
    int          passes;

    instruction_fetch dut (
        .clock             (clock),
        .reset             (reset),
        .instruction       (instruction),
        .address           (address),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .if_id_valid       (if_id_valid),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .halted            (halted),
        .fetch_count       (fetch_count)
    );

    assign instruction = imem[address[8:2]];

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        logic [31:0] jump_next;
        logic [31:0] halt_count;

        checks = 0;
        passes = 0;
        clock  = 1'b0;
        for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0100 + 32'(i);
        imem[0] = 32'h0232_4020;
        imem[4] = 32'h0800_0012;
`ifdef FETCH_JUMP_EN
        jump_next  = 32'h48;
        halt_count = 32'd63;
`else
        jump_next  = 32'h14;
        halt_count = 32'd76;
`endif

        // reset, with stall asserted to show reset wins
        reset = 1'b0; stall = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
        step(); step();
        check("rst_addr", address, 32'h0);
        check("rst_valid", 32'(if_id_valid), 32'h0);
        check("rst_instr", if_id_instruction, 32'h0);
        check("rst_pcp4", if_id_pc_plus4, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_count", fetch_count, 32'h0);

        // first fetch
        reset = 1'b1; stall = 1'b0;
        check("mem_word0", instruction, 32'h0232_4020);
        step();
        check("f1_instr", if_id_instruction, 32'h0232_4020);
        check("f1_pcp4", if_id_pc_plus4, 32'h4);
        check("f1_addr", address, 32'h4);
        check("f1_count", fetch_count, 32'h1);
        check("f1_valid", 32'(if_id_valid), 32'h1);

        // stall three cycles at address 8
        step();
        check("f2_addr", address, 32'h8);
        stall = 1'b1;
        step(); step(); step();
        check("stall_addr", address, 32'h8);
        check("stall_instr", if_id_instruction, 32'h0000_0101);
        check("stall_pcp4", if_id_pc_plus4, 32'h8);
        check("stall_count", fetch_count, 32'h2);
        check("stall_valid", 32'(if_id_valid), 32'h1);
        stall = 1'b0;
        step();
        check("resume_instr", if_id_instruction, 32'h0000_0102);
        check("resume_pcp4", if_id_pc_plus4, 32'hC);
        check("resume_addr", address, 32'hC);
        check("resume_count", fetch_count, 32'h3);

        // branch back to 8, then branch+stall at 8
        branch_taken = 1'b1; branch_target = 32'h8;
        step();
        check("br8_addr", address, 32'h8);
        check("br8_valid", 32'(if_id_valid), 32'h0);
        check("br8_count", fetch_count, 32'h3);
        branch_target = 32'h48; stall = 1'b1;
        step();
        check("brst_addr", address, 32'd72);
        check("brst_valid", 32'(if_id_valid), 32'h0);
        check("brst_count", fetch_count, 32'h3);
        branch_taken = 1'b0; stall = 1'b0;
        step();
        check("f48_instr", if_id_instruction, 32'h0000_0112);
        check("f48_pcp4", if_id_pc_plus4, 32'h4C);
        check("f48_count", fetch_count, 32'h4);
        check("f48_valid", 32'(if_id_valid), 32'h1);

        // misaligned branch target loads, then halts
        branch_taken = 1'b1; branch_target = 32'h4A;
        step();
        check("bad_addr", address, 32'h4A);
        check("bad_halted0", 32'(halted), 32'h0);
        branch_taken = 1'b0;
        step();
        check("bad_halted1", 32'(halted), 32'h1);
        check("bad_hold_addr", address, 32'h4A);
        check("bad_valid", 32'(if_id_valid), 32'h0);
        check("bad_count", fetch_count, 32'h4);
        branch_taken = 1'b1; branch_target = 32'h0; stall = 1'b1;
        step();
        check("halt_ign_br", address, 32'h4A);
        check("halt_stays", 32'(halted), 32'h1);
        reset = 1'b0;
        step();
        check("halt_rst_halted", 32'(halted), 32'h0);
        check("halt_rst_addr", address, 32'h0);
        check("halt_rst_count", fetch_count, 32'h0);

        // jump opcode at 0x10
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        step(); step(); step(); step();
        check("pre_j_addr", address, 32'h10);
        step();
        check("j_instr", if_id_instruction, 32'h0800_0012);
        check("j_valid", 32'(if_id_valid), 32'h1);
        check("j_pcp4", if_id_pc_plus4, 32'h14);
        check("j_next_addr", address, jump_next);
        check("j_count", fetch_count, 32'h5);

        // run off the end of legal memory
        n = 0;
        while (!halted && n < 200) begin
            step();
            n++;
        end
        check("end_halted", 32'(halted), 32'h1);
        check("end_addr", address, 32'd304);
        check("end_count", fetch_count, halt_count);
        check("end_valid", 32'(if_id_valid), 32'h0);
        reset = 1'b0;
        step();
        check("end_rst_halted", 32'(halted), 32'h0);
        check("end_rst_addr", address, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
